stoch_shrink_n: RTL

STOCH_SHRINK_N -- requirements
Module: stoch_shrink_n

---
 rtl/stoch_shrink_n.sv | 98 +++++++++
 1 files changed

// File: rtl/stoch_shrink_n.sv
// stoch_shrink_n : temporal stochastic bit shrinker.
// Each accepted input one opens a hold window of MemL cycles, and further
// input ones inside that window are suppressed. This collapses stretched
// runs back to single ones.
// Optional feature macro: SHRINK_DROPCNT_EN adds a saturating counter of
// suppressed ones on DropCount. When the macro is undefined, DropCount is 0.
module stoch_shrink_n #(
   parameter int unsigned MemL = 16,
   parameter int unsigned CntW = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            EN,
   input  logic            IN,
   output logic            OUT,
   output logic            BUSY,
   output logic [CntW-1:0] DropCount
);

   localparam int unsigned CW = $clog2(MemL);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_out;
   logic            w_out_nxt;

   // State, hold counter and output register; EN low holds everything but OUT
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_out   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_out   <= w_out_nxt;
      end
   end

   // Next-state: accept a one in IDLE, count the window down in HOLD
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_out_nxt   = 1'b0;
      if (EN) begin
         case (r_state)
            S_IDLE: begin
               if (IN) begin
                  w_out_nxt   = 1'b1;
                  w_cnt_nxt   = CW'(MemL - 1);
                  w_state_nxt = S_HOLD;
               end
            end
            S_HOLD: begin
               w_cnt_nxt = r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign OUT  = r_out;
   assign BUSY = (r_state == S_HOLD);

`ifdef SHRINK_DROPCNT_EN
   logic            w_drop_inc;
   logic [CntW-1:0] r_drop;

   // An enabled one arriving in HOLD is a dropped bit, including on the last HOLD cycle
   assign w_drop_inc = EN && IN && (r_state == S_HOLD);

   // Saturating count of dropped ones
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_drop <= '0;
      end else if (w_drop_inc && (r_drop != '1)) begin
         r_drop <= r_drop + CntW'(1);
      end
   end

   assign DropCount = r_drop;
`else
   assign DropCount = '0;
`endif

endmodule
